// File: rtl/mc_control_fsm.sv
// Main control FSM of the multi-cycle CPU: steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects and strobes.
module mc_control_fsm #(
    parameter bit EN_BNE = 1'b1,
    parameter bit EN_ORI = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [2:0] alu_control,
    output logic       illegal_instr,
    output logic [3:0] state_debug
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state, state_nx;

    // Returns {legal, alu_control} for an R-type funct field.
    function automatic logic [3:0] rtype_decode(input logic [5:0] f);
        case (f)
            6'b100000: rtype_decode = {1'b1, ALU_ADD};
            6'b100010: rtype_decode = {1'b1, ALU_SUB};
            6'b100100: rtype_decode = {1'b1, ALU_AND};
            6'b100101: rtype_decode = {1'b1, ALU_OR};
            6'b101010: rtype_decode = {1'b1, ALU_SLT};
            default:   rtype_decode = {1'b0, ALU_ADD};
        endcase
    endfunction

    logic [3:0] rdec;
    logic       is_bne, is_ori;

    assign rdec   = rtype_decode(funct);
    assign is_bne = EN_BNE && (opcode == OP_BNE);
    assign is_ori = EN_ORI && (opcode == OP_ORI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = S_FETCH;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        i_or_d        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        imm_zext      = 1'b0;
        pc_src        = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_control   = ALU_ADD;
        illegal_instr = 1'b0;

        case (state)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_nx  = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                alu_src_b = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW)          state_nx = S_MEMADR;
                else if (opcode == OP_RTYPE && rdec[3])          state_nx = S_EXECUTE;
                else if (opcode == OP_BEQ || is_bne)             state_nx = S_BRANCH;
                else if (opcode == OP_ADDI || is_ori)            state_nx = S_IEXEC;
                else if (opcode == OP_J)                         state_nx = S_JUMP;
                else begin
                    // PC already advanced in FETCH, so dropping back retires it as a NOP.
                    illegal_instr = 1'b1;
                    state_nx      = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nx  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                i_or_d   = 1'b1;
                state_nx = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                state_nx  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = rdec[2:0];
                state_nx    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_write    = (opcode == OP_BEQ) ? zero : ~zero;
            end
            S_IEXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = is_ori ? ALU_OR : ALU_ADD;
                imm_zext    = is_ori;
                state_nx    = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: state_nx = S_FETCH;
        endcase

        // Async reset must silence every strobe in the same cycle it is raised.
        if (reset) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            i_or_d        = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            imm_zext      = 1'b0;
            pc_src        = 2'b00;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            alu_control   = ALU_ADD;
            illegal_instr = 1'b0;
        end
    end

    assign state_debug = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected outputs are queued by
// the stimulus process and checked by an independent monitor on the falling edge.
module tb_mc_control_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, rst1, zero, mem_ready;
    logic [5:0] opcode, funct;

    logic       pc_write, ir_write, mem_write, reg_write, i_or_d, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       imm_zext, reg_dst, mem_to_reg, illegal_instr;
    logic [2:0] alu_control;
    logic [3:0] state_debug;

    logic       u1_pw, u1_iw, u1_mw, u1_rw, u1_iod, u1_a, u1_zx, u1_rd, u1_m2r, u1_ill;
    logic [1:0] u1_b, u1_ps;
    logic [2:0] u1_alu;
    logic [3:0] u1_st;

    mc_control_fsm #(.EN_BNE(1'b1), .EN_ORI(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .i_or_d(i_or_d),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
        .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_control(alu_control), .illegal_instr(illegal_instr),
        .state_debug(state_debug)
    );

    mc_control_fsm #(.EN_BNE(1'b0), .EN_ORI(1'b0)) dut_min (
        .clk(clk), .reset(rst1), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(u1_pw), .ir_write(u1_iw),
        .mem_write(u1_mw), .reg_write(u1_rw), .i_or_d(u1_iod),
        .alu_src_a(u1_a), .alu_src_b(u1_b), .imm_zext(u1_zx),
        .pc_src(u1_ps), .reg_dst(u1_rd), .mem_to_reg(u1_m2r),
        .alu_control(u1_alu), .illegal_instr(u1_ill), .state_debug(u1_st)
    );

    logic [20:0] act0;
    logic [4:0]  act1;
    assign act0 = {pc_write, ir_write, mem_write, reg_write, i_or_d, alu_src_a,
                   alu_src_b, imm_zext, pc_src, reg_dst, mem_to_reg,
                   alu_control, illegal_instr, state_debug};
    assign act1 = {u1_ill, u1_st};

    typedef struct {
        string       nm;
        logic [20:0] v0;
        logic [4:0]  v1;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 1'b0;

    // Values applied just after the next rising edge.
    logic       n_reset, n_rst1, n_zero;
    logic [5:0] n_op, n_fn;
    logic [4:0] u1e;

    // One clock cycle: apply staged inputs, queue the expected outputs.
    task automatic cyc(input string nm, input logic mr, input logic [3:0] st,
                       input logic [3:0] strb, input logic [1:0] iod_a,
                       input logic [1:0] b, input logic zx, input logic [1:0] ps,
                       input logic [1:0] rd_m2r, input logic [2:0] alu,
                       input logic ill);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = n_reset;
        rst1      = n_rst1;
        zero      = n_zero;
        opcode    = n_op;
        funct     = n_fn;
        mem_ready = mr;
        e.nm = nm;
        e.v0 = {strb, iod_a, b, zx, ps, rd_m2r, alu, ill, st};
        e.v1 = u1e;
        q.push_back(e);
    endtask

    task automatic t_reset();  cyc("reset",  1'b1, 4'd0,  4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0); endtask
    task automatic t_fetch(input logic mr);
                               cyc("fetch",  mr,   4'd0,  mr ? 4'b1100 : 4'b0000, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0); endtask
    task automatic t_decode(input logic ill);
                               cyc("decode", 1'b0, 4'd1,  4'b0000, 2'b00, 2'b11, 1'b0, 2'b00, 2'b00, 3'b010, ill); endtask
    task automatic t_memadr(); cyc("memadr", 1'b0, 4'd2,  4'b0000, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0); endtask
    task automatic t_memrd(input logic mr);
                               cyc("memrd",  mr,   4'd3,  4'b0000, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0); endtask
    task automatic t_memwb();  cyc("memwb",  1'b0, 4'd4,  4'b0001, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 3'b010, 1'b0); endtask
    task automatic t_memwr(input logic mr);
                               cyc("memwr",  mr,   4'd5,  4'b0010, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0); endtask
    task automatic t_exec(input logic [2:0] alu);
                               cyc("execute",1'b0, 4'd6,  4'b0000, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, alu,    1'b0); endtask
    task automatic t_aluwb();  cyc("aluwb",  1'b0, 4'd7,  4'b0001, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 3'b010, 1'b0); endtask
    task automatic t_branch(input logic pw);
                               cyc("branch", 1'b0, 4'd8,  {pw, 3'b000}, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 3'b110, 1'b0); endtask
    task automatic t_iexec(input logic [2:0] alu, input logic zx);
                               cyc("iexec",  1'b0, 4'd9,  4'b0000, 2'b01, 2'b10, zx,   2'b00, 2'b00, alu,    1'b0); endtask
    task automatic t_iwb();    cyc("iwb",    1'b0, 4'd10, 4'b0001, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0); endtask
    task automatic t_jump();   cyc("jump",   1'b0, 4'd11, 4'b1000, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 3'b010, 1'b0); endtask

    initial begin
        reset = 1'b1; rst1 = 1'b1; zero = 1'b0; mem_ready = 1'b0;
        opcode = 6'd0; funct = 6'd0;
        n_reset = 1'b1; n_rst1 = 1'b1; n_zero = 1'b0; n_op = 6'd0; n_fn = 6'd0;
        u1e = 5'd0;

        t_reset(); t_reset();
        n_reset = 1'b0;

        // R-type add, slt, and sub with a one-cycle fetch stall
        n_op = 6'b000000; n_fn = 6'b100000;
        t_fetch(1); t_decode(0); t_exec(3'b010); t_aluwb();
        n_fn = 6'b101010;
        t_fetch(1); t_decode(0); t_exec(3'b111); t_aluwb();
        n_fn = 6'b100010;
        t_fetch(0); t_fetch(1); t_decode(0); t_exec(3'b110); t_aluwb();
        // unsupported funct
        n_fn = 6'b000000;
        t_fetch(1); t_decode(1);

        // lw with three wait cycles in MEMRD
        n_op = 6'b100011;
        t_fetch(1); t_decode(0); t_memadr();
        t_memrd(0); t_memrd(0); t_memrd(0); t_memrd(1); t_memwb();

        // branches
        n_op = 6'b000100; n_zero = 1'b1;
        t_fetch(1); t_decode(0); t_branch(1);
        n_op = 6'b000101;
        t_fetch(1); t_decode(0); t_branch(0);
        n_zero = 1'b0;
        t_fetch(1); t_decode(0); t_branch(1);

        // ori / addi / j
        n_op = 6'b001101;
        t_fetch(1); t_decode(0); t_iexec(3'b001, 1'b1); t_iwb();
        n_op = 6'b001000;
        t_fetch(1); t_decode(0); t_iexec(3'b010, 1'b0); t_iwb();
        n_op = 6'b000010;
        t_fetch(1); t_decode(0); t_jump();

        // sw with two wait cycles, then sw cut short by reset
        n_op = 6'b101011;
        t_fetch(1); t_decode(0); t_memadr(); t_memwr(0); t_memwr(0); t_memwr(1);
        t_fetch(1); t_decode(0); t_memadr(); t_memwr(0);
        n_reset = 1'b1; t_reset();
        n_reset = 1'b0;

        // illegal opcode
        n_op = 6'b111111;
        t_fetch(1); t_decode(1);

        // bne on the reduced-ISA instance is illegal
        n_op = 6'b000101; n_zero = 1'b1; n_rst1 = 1'b0;
        u1e = 5'b0_0000; t_fetch(1);
        u1e = 5'b1_0001; t_decode(0);
        u1e = 5'b0_0000; n_rst1 = 1'b1; t_branch(0);
        t_fetch(1);

        @(posedge clk);
        #1 done = 1'b1;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                n_cmp++;
                if (q.size() != 0) begin
                    n_bad++;
                    $display("FAIL drain: %0d entries left, required 0", q.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (act0 !== e.v0 || act1 !== e.v1) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got %h/%h required %h/%h",
                             e.nm, $time, act0, act1, e.v0, e.v1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
